// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg: shared definitions for the DLFloat datapath.
//   - default exponent/fraction widths (DLFloat16: 1/6/9) and the bias function
//   - dlfloat16_t sign/exp/frac view of a DLFloat16 word
//   - bit positions inside the 5-bit exception flag vector
//   - NaN word and max-finite magnitude generators (formats up to 32 bits wide)
package dlfloat_pkg;

  localparam int DLF_EXP_W = 6;
  localparam int DLF_MAN_W = 9;

  // out_flags = {invalid, inexact, overflow, underflow, div_zero}
  localparam int FLG_INV = 4;
  localparam int FLG_NX  = 3;
  localparam int FLG_OF  = 2;
  localparam int FLG_UF  = 1;
  localparam int FLG_DZ  = 0;

  typedef struct packed {
    logic                 sign;
    logic [DLF_EXP_W-1:0] exp;
    logic [DLF_MAN_W-1:0] frac;
  } dlfloat16_t;

  function automatic int dlf_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // All-ones word of width 1+exp_w+man_w: the single NaN/Inf code.
  function automatic logic [31:0] dlf_nan(input int exp_w, input int man_w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 1 + exp_w + man_w; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Magnitude (sign excluded) of the largest finite value:
  // exponent all-ones, fraction all-ones minus one.
  function automatic logic [31:0] dlf_max_mag(input int exp_w, input int man_w);
    return (32'd1 << (exp_w + man_w)) - 32'd2;
  endfunction

endpackage

// File: rtl/dlfloat_lzc.sv
// dlfloat_lzc: leading-zero counter.
//   in_vec  [W-1:0]   value to scan from the MSB
//   lz_cnt  [CW-1:0]  number of zeros above the highest set bit (W when in_vec == 0)
module dlfloat_lzc #(
  parameter int W  = 13,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_vec,
  output logic [CW-1:0] lz_cnt
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    lz_cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_vec[i]) lz_cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/dlfloat_add_sub_pipe.sv
// dlfloat_add_sub_pipe: 3-stage pipelined DLFloat adder/subtractor.
//   in_valid/in_ready     operation handshake; in_ready = ~out_valid | out_ready
//   in_a, in_b, in_op     operands, 0 = A+B, 1 = A-B
//   in_tag                opaque tag returned with the result
//   out_valid/out_ready   result handshake
//   out_c, out_tag        result word and its tag
//   out_flags             {invalid, inexact, overflow, underflow, div_zero}
// Stages: 1 unpack/swap/align, 2 add/normalise, 3 round/pack/flags.
// Rounding: define DLFLOAT_ADDSUB_RNE_EN for round-to-nearest-even,
// otherwise the result is truncated (round toward zero).
module dlfloat_add_sub_pipe
  import dlfloat_pkg::*;
#(
  parameter int EXP_W = DLF_EXP_W,
  parameter int MAN_W = DLF_MAN_W,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_c,
  output logic [TAG_W-1:0]         out_tag,
  output logic [4:0]               out_flags
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 1;        // mantissa with hidden one
  localparam int AW     = MAN_W + 4;        // mantissa + guard/round/sticky
  localparam int EW2    = EXP_W + 2;        // signed exponent during normalise
  localparam int LZW    = $clog2(AW + 1);
  localparam int STAGES = 3;

  localparam logic [W-1:0]   NAN_WORD = W'(dlf_nan(EXP_W, MAN_W));
  localparam logic [W-2:0]   MAX_MAG  = (W-1)'(dlf_max_mag(EXP_W, MAN_W));
  localparam logic [EW2-1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};

  typedef struct packed {
    logic               nan;
    logic               both_zero;
    logic               zero_sign;
    logic               sign;
    logic               sub;
    logic [EXP_W-1:0]   exp;
    logic [AW-1:0]      lm;
    logic [AW-1:0]      sm;
    logic [TAG_W-1:0]   tag;
  } s1_t;

  typedef struct packed {
    logic               nan;
    logic               both_zero;
    logic               zero_sign;
    logic               sign;
    logic               zero;
    logic [EW2-1:0]     exp;   // two's complement
    logic [AW-1:0]      m;
    logic [TAG_W-1:0]   tag;
  } s2_t;

  typedef struct packed {
    logic [W-1:0]       c;
    logic [TAG_W-1:0]   tag;
    logic [4:0]         flags;
  } out_t;

  logic              adv;
  logic [STAGES:1]   vld_pipe_q;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  out_t              out_d, out_q;

  // One advance signal for the whole pipeline: it only stalls when the
  // output slot is full and not being drained.
  assign adv       = ~vld_pipe_q[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[STAGES];
  assign out_c     = out_q.c;
  assign out_tag   = out_q.tag;
  assign out_flags = out_q.flags;

  // ---------------- stage 1: unpack, swap, align ----------------
  logic             a_s, b_s, a_z, b_z, l_s, s_s, s_z, swap, s_stk;
  logic [EXP_W-1:0] a_e, b_e, l_e, s_e, e_diff;
  logic [MW-1:0]    a_m, b_m, l_m, s_m;
  logic [AW-1:0]    s_ext, s_sh;

  always_comb begin
    a_s = in_a[W-1];
    b_s = in_b[W-1] ^ in_op;
    a_e = in_a[W-2:MAN_W];
    b_e = in_b[W-2:MAN_W];
    a_z = (a_e == '0);
    b_z = (b_e == '0);
    // exponent 0 means zero whatever the fraction holds
    a_m = a_z ? '0 : {1'b1, in_a[MAN_W-1:0]};
    b_m = b_z ? '0 : {1'b1, in_b[MAN_W-1:0]};

    swap = {b_e, b_m} > {a_e, a_m};
    l_s  = swap ? b_s : a_s;
    l_e  = swap ? b_e : a_e;
    l_m  = swap ? b_m : a_m;
    s_s  = swap ? a_s : b_s;
    s_e  = swap ? a_e : b_e;
    s_m  = swap ? a_m : b_m;
    s_z  = swap ? a_z : b_z;

    // Right-align S; every bit pushed below the sticky position is ORed in.
    // Shifts of AW or more leave s_sh = 0 and the mask covers all of s_ext.
    e_diff = l_e - s_e;
    s_ext  = {s_m, 3'b000};
    s_sh   = s_ext >> e_diff;
    s_stk  = |(s_ext & ~({AW{1'b1}} << e_diff));

    s1_d           = '0;
    s1_d.nan       = (in_a == NAN_WORD) | (in_b == NAN_WORD);
    s1_d.both_zero = a_z & b_z;
    s1_d.zero_sign = a_s & b_s;
    s1_d.sign      = l_s;        // equal signs or larger magnitude: both give L's sign
    s1_d.sub       = l_s ^ s_s;
    s1_d.exp       = l_e;
    s1_d.lm        = {l_m, 3'b000};
    s1_d.sm        = s_z ? '0 : {s_sh[AW-1:1], s_sh[0] | s_stk};
    s1_d.tag       = in_tag;
  end

  // ---------------- stage 2: add/sub, normalise ----------------
  logic [AW:0]      sum;
  logic [AW-1:0]    sum_lo;
  logic [LZW-1:0]   lz;
  logic [EW2-1:0]   exp_ext;

  // |L| >= |S| after alignment, so the difference never goes negative.
  assign sum    = s1_q.sub ? ({1'b0, s1_q.lm} - {1'b0, s1_q.sm})
                           : ({1'b0, s1_q.lm} + {1'b0, s1_q.sm});
  assign sum_lo = sum[AW-1:0];

  dlfloat_lzc #(.W(AW), .CW(LZW)) u_lzc (
    .in_vec (sum_lo),
    .lz_cnt (lz)
  );

  always_comb begin
    exp_ext        = {2'b00, s1_q.exp};
    s2_d           = '0;
    s2_d.nan       = s1_q.nan;
    s2_d.both_zero = s1_q.both_zero;
    s2_d.zero_sign = s1_q.zero_sign;
    s2_d.sign      = s1_q.sign;
    s2_d.zero      = (sum == '0);
    s2_d.tag       = s1_q.tag;
    if (sum[AW]) begin
      // carry-out: the dropped LSB folds into sticky
      s2_d.m   = {sum[AW:2], sum[1] | sum[0]};
      s2_d.exp = exp_ext + EW2'(1);
    end else begin
      s2_d.m   = sum_lo << lz;
      s2_d.exp = exp_ext - EW2'(lz);
    end
  end

  // ---------------- stage 3: round, pack, flags ----------------
  logic [MW-1:0]    mant;
  logic             g, r, st, nx, rnd_up, ovf;
  logic [MW:0]      mr;
  logic [MAN_W-1:0] frac;
  logic [EW2-1:0]   exp_r;

  always_comb begin
    mant = s2_q.m[AW-1:3];
    g    = s2_q.m[2];
    r    = s2_q.m[1];
    st   = s2_q.m[0];
    nx   = g | r | st;
`ifdef DLFLOAT_ADDSUB_RNE_EN
    rnd_up = g & (r | st | mant[0]);
`else
    rnd_up = 1'b0;
`endif
    mr = {1'b0, mant} + (MW+1)'(rnd_up);
    if (mr[MW]) begin
      // rounding carried out of the hidden bit: mantissa becomes 1.000...
      frac  = mr[MAN_W:1];
      exp_r = s2_q.exp + EW2'(1);
    end else begin
      frac  = mr[MAN_W-1:0];
      exp_r = s2_q.exp;
    end
    // exponent max with all-ones fraction would alias the NaN magnitude
    ovf = (exp_r > EXP_MAX) || ((exp_r == EXP_MAX) && (&frac));

    out_d     = '0;
    out_d.tag = s2_q.tag;
    if (s2_q.nan) begin
      out_d.c              = NAN_WORD;
      out_d.flags[FLG_INV] = 1'b1;
    end else if (s2_q.both_zero) begin
      out_d.c = {s2_q.zero_sign, {(W-1){1'b0}}};
    end else if (s2_q.zero) begin
      out_d.c = '0;  // exact cancellation is +0
    end else if (s2_q.exp[EW2-1] || (s2_q.exp == '0)) begin
      out_d.c              = {s2_q.sign, {(W-1){1'b0}}};
      out_d.flags[FLG_UF]  = 1'b1;
      out_d.flags[FLG_NX]  = 1'b1;
    end else if (ovf) begin
      out_d.c              = {s2_q.sign, MAX_MAG};
      out_d.flags[FLG_OF]  = 1'b1;
      out_d.flags[FLG_NX]  = 1'b1;
    end else begin
      out_d.c              = {s2_q.sign, exp_r[EXP_W-1:0], frac};
      out_d.flags[FLG_NX]  = nx;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      out_q      <= '0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
      // output holds the last result while bubbles pass through
      if (vld_pipe_q[STAGES-1]) out_q <= out_d;
    end
  end

  // Datapath stages carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

endmodule

// File: doc/dlfloat_add_sub_pipe.md
# dlfloat_add_sub_pipe

Parametrised, fully pipelined DLFloat floating-point adder/subtractor with valid/ready handshakes on both sides, optional round-to-nearest-even, and per-result exception flags. It is the next-generation add/sub unit of the FPU datapath. It sits between the operand-issue logic and the FPU result/writeback arbiter, and accepts one operation per cycle when not stalled.

## Interface
- `EXP_W`, default 6: exponent width; bias = 2^(EXP_W-1)-1 (31 for DLFloat16).
- `MAN_W`, default 9: stored fraction width (hidden 1 implied).
- `TAG_W`, default 4: width of the opaque tag passed alongside each operation.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operation present.
- `in_ready` out 1: operation accepted when `in_valid & in_ready`.
- `in_a` in 1+EXP_W+MAN_W: operand A.
- `in_b` in 1+EXP_W+MAN_W: operand B.
- `in_op` in 1: 0 = A+B, 1 = A−B.
- `in_tag` in TAG_W: returned unchanged with the result.
- `out_valid` out 1: result present.
- `out_ready` in 1: result consumed when `out_valid & out_ready`.
- `out_c` out 1+EXP_W+MAN_W: result.
- `out_tag` out TAG_W: tag of the result.
- `out_flags` out 5: {invalid, inexact, overflow, underflow, div_zero}; div_zero is always 0.

## Operation
- Encoding: exponent field 0 means zero; the fraction is ignored and there are no subnormals. The all-ones word is the single NaN/Inf code. Max finite value = exponent all-ones, fraction all-ones−1 (0x7FFE / 0xFFFE for DLFloat16). Min normal = exponent 1, fraction 0.
- Stage 1: unpack, apply `in_op` to B's sign, swap so that |L| ≥ |S|, and right-align S by the exponent difference into MAN_W+4 bits (guard, round, sticky; sticky ORs all shifted-out bits). A zero operand bypasses alignment.
- Stage 2: add or subtract the magnitudes. Normalise with a leading-one detector: shift right by 1 on carry-out, otherwise shift left by the leading-zero count. Adjust the exponent in a signed EXP_W+2-bit field.
- Stage 3: round (see Configuration), renormalise if rounding carries out, then pack and set flags.
- Sign: if the signs are equal, the common sign. Otherwise the sign of the larger magnitude. An exact zero result is +0.
- Either operand NaN: result all-ones, invalid=1, all other flags 0.
- Both operands zero: +0, or −0 only if both operands carry an effective negative sign. No flags.
- Overflow (exponent after rounding > max, or equal to max with fraction all-ones): result ±max finite, overflow=1, inexact=1.
- Underflow (normalised exponent ≤ 0): result ±0, underflow=1, inexact=1.
- inexact=1 whenever guard|round|sticky ≠ 0 before rounding.

## Timing
- Latency is 3 cycles from acceptance to `out_valid` when there is no back-pressure. Throughput is 1 per cycle.
- A single global advance signal drives the pipeline: `adv = ~out_valid | out_ready`, and `in_ready = adv`, which is combinational. Stages hold their contents when `adv` is 0. Inputs presented while `in_ready` is 0 are ignored.
- Per-stage valid bits advance with `adv`. Results leave in acceptance order, and none are dropped or duplicated.
- `out_c`, `out_tag` and `out_flags` are stable while `out_valid & ~out_ready`.
- Reset (rst_n low at a clk edge) clears all stage valid bits. `out_valid` = 0, `out_c` = 0, `out_tag` = 0, `out_flags` = 0. In-flight operations are discarded, even when reset is asserted mid-operation. `in_ready` = 1 during the first cycle after reset.

## Configuration
- `DLFLOAT_ADDSUB_RNE_EN` defined: round-to-nearest, ties-to-even, using guard/round/sticky.
- Not defined: truncate, i.e. round toward zero. The overflow result is still ±max finite.
- The inexact flag is computed identically in both modes.

## Structure
- Package `dlfloat_pkg`:
  - `EXP_W`/`MAN_W` defaults and the bias function.
  - Typedef `dlfloat16_t` (sign/exp/frac struct).
  - Flag bit-index constants.
  - NaN and max-finite constant functions.
- Sub-module `dlfloat_lzc`: parametrised leading-zero counter, used in stage 2.

## Test plan
- 0x3E00 + 0x3E00, op=0 → 0x4000, flags 0. 0x3E00 − 0x3E00 → 0x0000, flags 0.
- 0xFFFF + 0x3E00 → 0xFFFF, flags = invalid only (0b10000).
- 0x7FFE + 0x7FFE → 0x7FFE, overflow=1, inexact=1. 0xFFFE + 0xFFFE → 0xFFFE, same flags.
- 0x0201 − 0x0200 → 0x0000, underflow=1, inexact=1.
- 0x3E01 + 0x2A00 → 0x3E02 with RNE_EN, 0x3E01 without; inexact=1 in both modes.
- Issue 6 tagged operations back-to-back with `out_ready` low for cycles 4–8: `in_ready` drops, outputs hold stable, and all 6 results emerge in tag order 0..5. Assert reset mid-stream: `out_valid` = 0 on the next cycle.
